// File: rtl/tft_timing_gen.sv
// Raster timing generator for a TFT panel: hsync/vsync/de plus pixel pull from a frame FIFO.
// Optional macro TFT_UNDERFLOW_COUNT_EN adds a saturating underflow_count output.
module tft_timing_gen #(
  parameter int CNT_W = 16,
  parameter int PIX_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lock,
  input  logic             enable,
  input  logic [CNT_W-1:0] h_active,
  input  logic [CNT_W-1:0] h_fp,
  input  logic [CNT_W-1:0] h_sync,
  input  logic [CNT_W-1:0] h_bp,
  input  logic [CNT_W-1:0] v_active,
  input  logic [CNT_W-1:0] v_fp,
  input  logic [CNT_W-1:0] v_sync,
  input  logic [CNT_W-1:0] v_bp,
  input  logic [PIX_W-1:0] pixel_data,
  input  logic             pixel_valid,
  output logic             pixel_ready,
  output logic             tft_hsync,
  output logic             tft_vsync,
  output logic             tft_de,
  output logic [PIX_W-1:0] tft_rgb,
  output logic             frame_start,
  output logic             underflow
`ifdef TFT_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]      underflow_count
`endif
);

  typedef enum logic {IDLE, RUN} top_t;
  typedef enum logic [1:0] {SYNC = 2'd0, BP = 2'd1, ACTIVE = 2'd2, FP = 2'd3} axis_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  top_t             top_reg;
  axis_t            h_state_reg, v_state_reg;
  axis_t            h_next, v_next;
  logic [CNT_W-1:0] h_cnt_reg, v_cnt_reg;
  logic             first_reg;
  logic             enable_d_reg;
  logic [CNT_W-1:0] h_in [4];
  logic [CNT_W-1:0] v_in [4];
  logic [CNT_W-1:0] h_sh_reg [4];
  logic [CNT_W-1:0] v_sh_reg [4];
  logic             run, line_end, frame_wrap, load_cfg;

  // Field arrays indexed by axis state so the next field length is a simple lookup.
  assign h_in[0] = h_sync;
  assign h_in[1] = h_bp;
  assign h_in[2] = h_active;
  assign h_in[3] = h_fp;
  assign v_in[0] = v_sync;
  assign v_in[1] = v_bp;
  assign v_in[2] = v_active;
  assign v_in[3] = v_fp;

  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] f);
    return (f == '0) ? '0 : f - ONE;
  endfunction

  assign run         = (top_reg == RUN);
  assign h_next      = axis_t'(h_state_reg + 2'd1);
  assign v_next      = axis_t'(v_state_reg + 2'd1);
  assign line_end    = (h_state_reg == FP) && (h_cnt_reg == '0);
  assign frame_wrap  = line_end && (v_state_reg == FP) && (v_cnt_reg == '0);
  assign pixel_ready = run && (h_state_reg == ACTIVE) && (v_state_reg == ACTIVE);
  assign load_cfg    = lock && enable && (!run || frame_wrap);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (rst) begin
          h_sh_reg[gi] <= '0;
          v_sh_reg[gi] <= '0;
        end else if (load_cfg) begin
          h_sh_reg[gi] <= h_in[gi];
          v_sh_reg[gi] <= v_in[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      top_reg      <= IDLE;
      h_state_reg  <= SYNC;
      v_state_reg  <= SYNC;
      h_cnt_reg    <= '0;
      v_cnt_reg    <= '0;
      first_reg    <= 1'b0;
      enable_d_reg <= 1'b0;
      tft_hsync    <= 1'b1;
      tft_vsync    <= 1'b1;
      tft_de       <= 1'b0;
      tft_rgb      <= '0;
      frame_start  <= 1'b0;
      underflow    <= 1'b0;
`ifdef TFT_UNDERFLOW_COUNT_EN
      underflow_count <= 16'h0000;
`endif
    end else begin
      enable_d_reg <= enable;

      // Panel outputs are a one-cycle-delayed image of the current raster position.
      if (!lock) begin
        tft_hsync   <= 1'b1;
        tft_vsync   <= 1'b1;
        tft_de      <= 1'b0;
        tft_rgb     <= '0;
        frame_start <= 1'b0;
      end else begin
        tft_hsync   <= !(run && h_state_reg == SYNC);
        tft_vsync   <= !(run && v_state_reg == SYNC);
        tft_de      <= pixel_ready;
        tft_rgb     <= (pixel_ready && pixel_valid) ? pixel_data : '0;
        frame_start <= run && first_reg;
      end

      if (enable && !enable_d_reg) begin
        underflow <= 1'b0;
`ifdef TFT_UNDERFLOW_COUNT_EN
        underflow_count <= 16'h0000;
`endif
      end else if (pixel_ready && !pixel_valid) begin
        underflow <= 1'b1;
`ifdef TFT_UNDERFLOW_COUNT_EN
        if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
`endif
      end

      case (top_reg)
        IDLE: begin
          h_state_reg <= SYNC;
          v_state_reg <= SYNC;
          h_cnt_reg   <= ld(h_sync);
          v_cnt_reg   <= ld(v_sync);
          first_reg   <= 1'b0;
          if (lock && enable) begin
            top_reg   <= RUN;
            first_reg <= 1'b1;
          end
        end
        default: begin
          first_reg <= 1'b0;
          if (!lock) begin
            top_reg     <= IDLE;
            h_state_reg <= SYNC;
            v_state_reg <= SYNC;
          end else begin
            if (h_cnt_reg != '0) begin
              h_cnt_reg <= h_cnt_reg - ONE;
            end else begin
              h_state_reg <= h_next;
              h_cnt_reg   <= ld(h_sh_reg[h_next]);
            end
            if (line_end) begin
              if (v_cnt_reg != '0) begin
                v_cnt_reg <= v_cnt_reg - ONE;
              end else begin
                v_state_reg <= v_next;
                v_cnt_reg   <= ld(v_sh_reg[v_next]);
              end
            end
            // The next frame starts from freshly sampled fields, not the old shadows.
            if (frame_wrap) begin
              if (enable) begin
                h_cnt_reg <= ld(h_sync);
                v_cnt_reg <= ld(v_sync);
                first_reg <= 1'b1;
              end else begin
                top_reg <= IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tft_timing_gen.sv
// Self-checking bench for tft_timing_gen: frame-position model plus directed and random scenarios.
module tb_tft_timing_gen;

  logic        clk = 1'b0;
  logic        rst, lock, enable;
  logic [15:0] h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready, tft_hsync, tft_vsync, tft_de, frame_start, underflow;
  logic [23:0] tft_rgb;
`ifdef TFT_UNDERFLOW_COUNT_EN
  logic [15:0] underflow_count;
`endif

  tft_timing_gen dut (
    .clk(clk), .rst(rst), .lock(lock), .enable(enable),
    .h_active(h_active), .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp),
    .v_active(v_active), .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .tft_hsync(tft_hsync), .tft_vsync(tft_vsync), .tft_de(tft_de), .tft_rgb(tft_rgb),
    .frame_start(frame_start), .underflow(underflow)
`ifdef TFT_UNDERFLOW_COUNT_EN
    , .underflow_count(underflow_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a running flag, the cycle position inside the frame, and the frame's sampled fields.
  bit  m_run = 0;
  int  m_pos = 0;
  int  m_hf[4];
  int  m_vf[4];
  bit  m_en_d = 0;
  bit  e_hs = 1, e_vs = 1, e_de = 0, e_fs = 0, e_uf = 0;
  logic [23:0] e_rgb = '0;
  int  e_ucnt = 0;
  bit  chk_en = 0;

  function automatic int fix(input logic [15:0] f);
    return (f == 16'd0) ? 1 : int'(f);
  endfunction

  function automatic int line_len();
    return m_hf[0] + m_hf[1] + m_hf[2] + m_hf[3];
  endfunction

  function automatic int frame_len();
    return line_len() * (m_vf[0] + m_vf[1] + m_vf[2] + m_vf[3]);
  endfunction

  function automatic bit in_hsync(input int p);
    return (p % line_len()) < m_hf[0];
  endfunction

  function automatic bit in_vsync(input int p);
    return (p / line_len()) < m_vf[0];
  endfunction

  function automatic bit in_active(input int p);
    int x  = p % line_len();
    int ln = p / line_len();
    return x >= m_hf[0] + m_hf[1] && x < m_hf[0] + m_hf[1] + m_hf[2] &&
           ln >= m_vf[0] + m_vf[1] && ln < m_vf[0] + m_vf[1] + m_vf[2];
  endfunction

  task automatic load_model_cfg();
    m_hf[0] = fix(h_sync); m_hf[1] = fix(h_bp); m_hf[2] = fix(h_active); m_hf[3] = fix(h_fp);
    m_vf[0] = fix(v_sync); m_vf[1] = fix(v_bp); m_vf[2] = fix(v_active); m_vf[3] = fix(v_fp);
  endtask

  // Observed statistics used by the hand-computed expectations.
  int cyc = 0, last_fs = -1, fs_gap = 0, fs_count = 0;
  int last_hs = -1, hs_gap = 0, de_run = 0, last_de_len = 0;
  bit prev_hs = 1;
  bit cap_en = 0;
  int cap_n = 0;
  logic [23:0] cap[8];

  always @(negedge clk) begin
    bit exp_ready;
    cyc++;
    exp_ready = m_run && in_active(m_pos);
    if (chk_en) begin
      chk("pixel_ready", {31'd0, pixel_ready}, {31'd0, exp_ready});
      chk("tft_hsync", {31'd0, tft_hsync}, {31'd0, e_hs});
      chk("tft_vsync", {31'd0, tft_vsync}, {31'd0, e_vs});
      chk("tft_de", {31'd0, tft_de}, {31'd0, e_de});
      chk("tft_rgb", {8'd0, tft_rgb}, {8'd0, e_rgb});
      chk("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
      chk("underflow", {31'd0, underflow}, {31'd0, e_uf});
`ifdef TFT_UNDERFLOW_COUNT_EN
      chk("underflow_count", {16'd0, underflow_count}, e_ucnt);
`endif
    end

    if (frame_start === 1'b1) begin
      if (last_fs >= 0) fs_gap = cyc - last_fs;
      last_fs = cyc;
      fs_count++;
    end
    if (tft_hsync === 1'b0 && prev_hs) begin
      if (last_hs >= 0) hs_gap = cyc - last_hs;
      last_hs = cyc;
    end
    prev_hs = (tft_hsync !== 1'b0);
    if (tft_de === 1'b1) begin
      de_run++;
      if (cap_en && cap_n < 8) begin
        cap[cap_n] = tft_rgb;
        cap_n++;
      end
    end else begin
      if (de_run > 0) last_de_len = de_run;
      de_run = 0;
    end

    // Expected registered outputs for the next cycle.
    if (rst || !lock) begin
      e_hs = 1; e_vs = 1; e_de = 0; e_rgb = '0; e_fs = 0;
    end else begin
      e_hs  = !(m_run && in_hsync(m_pos));
      e_vs  = !(m_run && in_vsync(m_pos));
      e_de  = exp_ready;
      e_rgb = (exp_ready && pixel_valid) ? pixel_data : 24'd0;
      e_fs  = m_run && (m_pos == 0);
    end
    if (rst || (enable && !m_en_d)) begin
      e_uf = 0; e_ucnt = 0;
    end else if (exp_ready && !pixel_valid) begin
      e_uf = 1;
      if (e_ucnt < 65535) e_ucnt++;
    end
    m_en_d = rst ? 1'b0 : enable;

    if (rst) begin
      m_run = 0;
    end else if (!m_run) begin
      if (lock && enable) begin
        m_run = 1; m_pos = 0; load_model_cfg();
      end
    end else if (!lock) begin
      m_run = 0;
    end else if (m_pos == frame_len() - 1) begin
      if (enable) begin
        m_pos = 0; load_model_cfg();
      end else begin
        m_run = 0;
      end
    end else begin
      m_pos++;
    end
  end

  bit pat_mode = 1;
  int pix_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (pat_mode) begin
      pixel_data = pix_cnt[23:0];
      if (pixel_ready) pix_cnt++;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_cfg(input int ha, hfp, hs, hb, va, vfp, vs, vb);
    h_active = 16'(ha); h_fp = 16'(hfp); h_sync = 16'(hs); h_bp = 16'(hb);
    v_active = 16'(va); v_fp = 16'(vfp); v_sync = 16'(vs); v_bp = 16'(vb);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!pixel_ready && n < 200) begin
      step();
      n++;
    end
    if (!pixel_ready) begin
      errors++;
      $display("FAIL %s: pixel_ready never asserted within 200 cycles", nm);
    end
  endtask

  initial begin
    int fs_before;
    rst = 1; lock = 0; enable = 0; pixel_valid = 1; pixel_data = '0;
    set_cfg(4, 1, 2, 1, 2, 1, 1, 1);
    @(posedge clk); #1;
    chk_en = 1;
    steps(3);
    rst = 0;
    step();

    // Basic 4x2 raster with an incrementing pixel pattern.
    pix_cnt = 0; pixel_data = '0; cap_en = 1;
    lock = 1; enable = 1;
    steps(100);
    for (int i = 0; i < 8; i++) chk($sformatf("rgb_seq%0d", i), {8'd0, cap[i]}, i);
    chk("frame_period_40", fs_gap, 40);
    chk("line_period_8", hs_gap, 8);
    chk("de_len_4", last_de_len, 4);
    cap_en = 0;

    // Single dropped pixel.
    wait_ready("underflow_setup");
    pixel_valid = 0;
    step();
    pixel_valid = 1;
    steps(60);
    chk("underflow_sticky", {31'd0, underflow}, 32'd1);
`ifdef TFT_UNDERFLOW_COUNT_EN
    chk("underflow_count_1", {16'd0, underflow_count}, 32'd1);
`endif
    chk("no_timing_shift", fs_gap, 40);

    // Mid-frame h_active change takes effect at the next frame.
    steps(10);
    h_active = 16'd6;
    steps(120);
    chk("de_len_6", last_de_len, 6);
    chk("line_period_10", hs_gap, 10);
    chk("frame_period_50", fs_gap, 50);

    // enable drop: finish frame then idle.
    steps(7);
    enable = 0;
    steps(2);
    fs_before = fs_count;
    steps(80);
    chk("no_frame_start_after_disable", fs_count, fs_before);
    chk("idle_hsync", {31'd0, tft_hsync}, 32'd1);
    chk("idle_vsync", {31'd0, tft_vsync}, 32'd1);
    chk("idle_de", {31'd0, tft_de}, 32'd0);

    // lock drop inside the active area, then relock.
    enable = 1;
    wait_ready("lock_drop_setup");
    lock = 0;
    step();
    chk("unlock_de", {31'd0, tft_de}, 32'd0);
    chk("unlock_vsync", {31'd0, tft_vsync}, 32'd1);
    steps(5);
    lock = 1;
    @(negedge clk); chk("relock_fs_a", {31'd0, frame_start}, 32'd0);
    @(negedge clk); chk("relock_fs_b", {31'd0, frame_start}, 32'd0);
    @(negedge clk); chk("relock_fs_c", {31'd0, frame_start}, 32'd1);
    step();

    // All-zero fields behave as length 1.
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    steps(120);
    chk("frame_period_16", fs_gap, 16);
    chk("line_period_4", hs_gap, 4);
    chk("de_len_1", last_de_len, 1);

    // Randomized configurations, data, valid drops, enable and lock toggles.
    pat_mode = 0;
    for (int it = 0; it < 20; it++) begin
      set_cfg($urandom_range(1, 5), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      for (int c = 0; c < 80; c++) begin
        pixel_data  = 24'($urandom);
        pixel_valid = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 99) < 2) lock = ~lock;
        else if (!lock && $urandom_range(0, 3) == 0) lock = 1;
        if ($urandom_range(0, 99) < 2) enable = ~enable;
        else if (!enable && $urandom_range(0, 19) == 0) enable = 1;
        step();
      end
    end
    pixel_valid = 1;
    steps(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
